// File: rtl/rgb_seq_ctrl_if.sv
// Register bus between spi_slave and the RGB sequencer.
// The master drives we/addr/wdat and the block returns combinational rdat.
interface rgb_seq_ctrl_if;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdat;
    logic [31:0] rdat;

    modport master (output we, output addr, output wdat, input rdat);
    modport slave  (input we, input addr, input wdat, output rdat);
endinterface

// File: rtl/rgb_seq_ctrl.sv
// Register-programmed RGB pattern sequencer.
// Steps an 8-entry duty/duration table on a prescaled tick and drives three PWM outputs.
module rgb_seq_ctrl #(
    parameter logic [6:0]  BASE      = 7'h10,
    parameter logic [15:0] PRESC_RST = 16'd0
) (
    input  logic          clk,
    input  logic          reset,
    rgb_seq_ctrl_if.slave bus,
    output logic          pwm_r,
    output logic          pwm_g,
    output logic          pwm_b,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic        ctrl_en;
    logic        ctrl_loop;
    logic [15:0] presc;
    logic [2:0]  nstep;
    logic [31:0] step_mem [8];

    logic [2:0]  cur_step;
    logic [2:0]  nxt_step;
    logic        done;
    logic [15:0] presc_cnt;
    logic [7:0]  dur_cnt;
    logic [7:0]  act_r, act_g, act_b;
    logic [7:0]  sh_r, sh_g, sh_b;
    logic [7:0]  pwm_cnt;

    logic        hit;
    logic [3:0]  off;
    logic        wr_ctrl;
    logic        wr_status;

    assign hit       = (bus.addr[6:4] == BASE[6:4]);
    assign off       = bus.addr[3:0];
    assign wr_ctrl   = bus.we && hit && (off == 4'h0);
    assign wr_status = bus.we && hit && (off == 4'h3);
    // Equality compare: NSTEP lowered below cur_step lets the sequence run to 7 and wrap.
    assign nxt_step  = (cur_step == nstep) ? 3'd0 : cur_step + 3'd1;
    assign busy      = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_loop <= 1'b0;
            presc     <= PRESC_RST;
            nstep     <= '0;
            for (int unsigned i = 0; i < 8; i++) step_mem[i] <= '0;
        end else if (bus.we && hit) begin
            if (off[3]) begin
                step_mem[off[2:0]] <= bus.wdat;
            end else begin
                case (off[2:0])
                    3'd0: begin
                        ctrl_en   <= bus.wdat[0];
                        ctrl_loop <= bus.wdat[1];
                    end
                    3'd1:    presc <= bus.wdat[15:0];
                    3'd2:    nstep <= bus.wdat[2:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_step  <= '0;
            done      <= 1'b0;
            presc_cnt <= '0;
            dur_cnt   <= '0;
            act_r     <= '0;
            act_g     <= '0;
            act_b     <= '0;
            sh_r      <= '0;
            sh_g      <= '0;
            sh_b      <= '0;
            pwm_cnt   <= '0;
            pwm_r     <= 1'b0;
            pwm_g     <= 1'b0;
            pwm_b     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm_r   <= (pwm_cnt < sh_r);
            pwm_g   <= (pwm_cnt < sh_g);
            pwm_b   <= (pwm_cnt < sh_b);
            if (pwm_cnt == '1) begin
                sh_r <= act_r;
                sh_g <= act_g;
                sh_b <= act_b;
            end

            if (wr_status && bus.wdat[8]) done <= 1'b0;

            // A CTRL write overrides any tick in the same cycle; the shadow clear wins over a frame reload.
            if (wr_ctrl) begin
                if (bus.wdat[0]) begin
                    state     <= RUN;
                    cur_step  <= '0;
                    act_r     <= step_mem[0][7:0];
                    act_g     <= step_mem[0][15:8];
                    act_b     <= step_mem[0][23:16];
                    presc_cnt <= presc;
                    dur_cnt   <= step_mem[0][31:24];
                end else begin
                    state    <= IDLE;
                    cur_step <= '0;
                    act_r    <= '0;
                    act_g    <= '0;
                    act_b    <= '0;
                    sh_r     <= '0;
                    sh_g     <= '0;
                    sh_b     <= '0;
                end
            end else if (state == RUN) begin
                if (presc_cnt != '0) begin
                    presc_cnt <= presc_cnt - 16'd1;
                end else begin
                    presc_cnt <= presc;
                    if (dur_cnt != '0) begin
                        dur_cnt <= dur_cnt - 8'd1;
                    end else if (cur_step == nstep && !ctrl_loop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cur_step <= nxt_step;
                        act_r    <= step_mem[nxt_step][7:0];
                        act_g    <= step_mem[nxt_step][15:8];
                        act_b    <= step_mem[nxt_step][23:16];
                        dur_cnt  <= step_mem[nxt_step][31:24];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.rdat = '0;
        if (hit) begin
            if (off[3]) begin
                bus.rdat = step_mem[off[2:0]];
            end else begin
                case (off[2:0])
                    3'd0:    bus.rdat = {30'd0, ctrl_loop, ctrl_en};
                    3'd1:    bus.rdat = {16'd0, presc};
                    3'd2:    bus.rdat = {29'd0, nstep};
                    3'd3:    bus.rdat = {23'd0, done, 1'b0, cur_step, 3'd0, busy};
                    default: bus.rdat = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Self-checking bench for rgb_seq_ctrl: randomized step tables checked against
// step timelines and PWM duty counts derived from the sequencing rules.
module tb_rgb_seq_ctrl;

    localparam logic [6:0]  BASE     = 7'h10;
    localparam logic [15:0] PRST     = 16'h0007;
    localparam logic [6:0]  A_CTRL   = 7'h10;
    localparam logic [6:0]  A_PRESC  = 7'h11;
    localparam logic [6:0]  A_NSTEP  = 7'h12;
    localparam logic [6:0]  A_STATUS = 7'h13;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pwm_r, pwm_g, pwm_b, busy;
    int   checks = 0;
    int   errors = 0;

    rgb_seq_ctrl_if bus ();

    rgb_seq_ctrl #(.BASE(BASE), .PRESC_RST(PRST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .pwm_r (pwm_r),
        .pwm_g (pwm_g),
        .pwm_b (pwm_b),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1; bus.addr = a; bus.wdat = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0; bus.addr = A_STATUS; bus.wdat = '0;
        #1;
    endtask

    task automatic rd(input logic [6:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        #1;
        d = bus.rdat;
    endtask

    task automatic load_table(input logic [15:0] p, input logic [2:0] n, input logic [31:0] st [8]);
        for (int s = 0; s < 8; s++) wr(7'(7'h18 + s), st[s]);
        wr(A_PRESC, {16'd0, p});
        wr(A_NSTEP, {29'd0, n});
        wr(A_STATUS, 32'h100);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rd(A_CTRL, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
        rd(A_PRESC, d);  checks++; if (d !== {16'd0, PRST}) begin errors++; $display("FAIL reset_presc got %h want %h", d, PRST); end
        rd(A_NSTEP, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_nstep got %h want 0", d); end
        rd(A_STATUS, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
        rd(7'h1F, d);    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_step7 got %h want 0", d); end
        checks++;
        if ({pwm_r, pwm_g, pwm_b, busy} !== 4'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 0000", {pwm_r, pwm_g, pwm_b, busy});
        end
    endtask

    task automatic test_single_shot();
        for (int c = 0; c < 4; c++) begin
            logic [31:0] st [8];
            logic [15:0] p;
            logic [2:0]  n;
            int          exp_q[$];
            int          bad_i;
            logic [31:0] bad_v;
            int          hi_r, hi_g, hi_b;
            p = (c == 0) ? 16'd1 : 16'($urandom_range(0, 3));
            n = (c == 0) ? 3'd1 : 3'($urandom_range(0, 3));
            for (int s = 0; s < 8; s++) begin
                st[s] = $urandom();
                st[s][31:24] = 8'($urandom_range(0, 3));
            end
            if (c == 0) begin
                st[0] = 32'h020000FF;
                st[1] = 32'h00008000;
            end
            for (int s = 0; s <= int'(n); s++)
                repeat ((int'(p) + 1) * (int'(st[s][31:24]) + 1)) exp_q.push_back(s);
            load_table(p, n, st);
            wr(A_CTRL, 32'h1);
            bad_i = -1;
            bad_v = '0;
            foreach (exp_q[i]) begin
                if ((bus.rdat !== 32'((exp_q[i] << 4) | 1) || busy !== 1'b1) && bad_i < 0) begin
                    bad_i = i; bad_v = bus.rdat;
                end
                @(posedge clk); #2;
            end
            checks++;
            if (bad_i >= 0) begin
                errors++;
                $display("FAIL single_run case %0d cycle %0d status %h want %h", c, bad_i, bad_v, 32'((exp_q[bad_i] << 4) | 1));
            end
            checks++;
            if (busy !== 1'b0 || bus.rdat !== (32'h100 | 32'(n) << 4)) begin
                errors++;
                $display("FAIL single_done case %0d busy %b status %h want busy 0 status %h", c, busy, bus.rdat, 32'h100 | 32'(n) << 4);
            end
            if (c == 0) begin
                repeat (300) @(posedge clk);
                #2;
                hi_r = 0; hi_g = 0; hi_b = 0;
                repeat (256) begin
                    hi_r += int'(pwm_r); hi_g += int'(pwm_g); hi_b += int'(pwm_b);
                    @(posedge clk); #2;
                end
                checks++;
                if (hi_r != 0 || hi_g != 128 || hi_b != 0) begin
                    errors++; $display("FAIL done_pwm r/g/b high %0d/%0d/%0d want 0/128/0", hi_r, hi_g, hi_b);
                end
            end
            wr(A_STATUS, 32'h100);
            checks++;
            if (bus.rdat !== 32'(n) << 4) begin
                errors++; $display("FAIL done_clear status %h want %h", bus.rdat, 32'(n) << 4);
            end
        end
    endtask

    task automatic test_loop();
        for (int c = 0; c < 3; c++) begin
            logic [31:0] st [8];
            logic [15:0] p;
            logic [2:0]  n;
            int          per[$];
            int          bad_i;
            logic [31:0] bad_v;
            p = (c == 0) ? 16'd1 : 16'($urandom_range(0, 2));
            n = (c == 0) ? 3'd1 : 3'($urandom_range(1, 7));
            for (int s = 0; s < 8; s++) begin
                st[s] = $urandom();
                st[s][31:24] = 8'($urandom_range(0, 2));
            end
            if (c == 0) begin
                st[0] = 32'h020000FF;
                st[1] = 32'h00008000;
            end
            for (int s = 0; s <= int'(n); s++)
                repeat ((int'(p) + 1) * (int'(st[s][31:24]) + 1)) per.push_back(s);
            load_table(p, n, st);
            wr(A_CTRL, 32'h3);
            bad_i = -1;
            bad_v = '0;
            for (int i = 0; i < 100; i++) begin
                if ((bus.rdat !== 32'((per[i % per.size()] << 4) | 1) || busy !== 1'b1) && bad_i < 0) begin
                    bad_i = i; bad_v = bus.rdat;
                end
                @(posedge clk); #2;
            end
            checks++;
            if (bad_i >= 0) begin
                errors++;
                $display("FAIL loop_run case %0d cycle %0d status %h want %h", c, bad_i, bad_v, 32'((per[bad_i % per.size()] << 4) | 1));
            end
            wr(A_CTRL, 32'h0);
        end
    endtask

    task automatic test_pwm_duty();
        for (int c = 0; c < 3; c++) begin
            logic [31:0] st [8];
            logic [7:0]  r, g, b;
            int          hi_r, hi_g, hi_b;
            r = (c == 0) ? 8'h40 : 8'($urandom());
            g = (c == 0) ? 8'h00 : 8'($urandom());
            b = (c == 0) ? 8'hFF : 8'($urandom());
            for (int s = 0; s < 8; s++) st[s] = '0;
            st[0] = {8'hFF, b, g, r};
            load_table(16'hFFFF, 3'd0, st);
            wr(A_CTRL, 32'h1);
            repeat (260) @(posedge clk);
            #2;
            hi_r = 0; hi_g = 0; hi_b = 0;
            repeat (256) begin
                hi_r += int'(pwm_r); hi_g += int'(pwm_g); hi_b += int'(pwm_b);
                @(posedge clk); #2;
            end
            checks++;
            if (hi_r != int'(r) || hi_g != int'(g) || hi_b != int'(b)) begin
                errors++;
                $display("FAIL pwm_duty case %0d high %0d/%0d/%0d want %0d/%0d/%0d", c, hi_r, hi_g, hi_b, r, g, b);
            end
            wr(A_CTRL, 32'h0);
        end
    endtask

    task automatic test_stop();
        logic [31:0] st [8];
        int          bad;
        for (int s = 0; s < 8; s++) st[s] = 32'h05FFFFFF;
        load_table(16'd3, 3'd7, st);
        wr(A_CTRL, 32'h3);
        repeat (300) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || (pwm_r & pwm_g & pwm_b) !== 1'b1 && {pwm_r, pwm_g, pwm_b} !== 3'b000) begin
            errors++; $display("FAIL stop_pre busy %b pwm %b want busy 1", busy, {pwm_r, pwm_g, pwm_b});
        end
        wr(A_CTRL, 32'h0);
        checks++;
        if (busy !== 1'b0 || bus.rdat !== 32'h0) begin
            errors++; $display("FAIL stop_state busy %b status %h want 0 0", busy, bus.rdat);
        end
        @(posedge clk); #2;
        bad = 0;
        repeat (20) begin
            if ({pwm_r, pwm_g, pwm_b} !== 3'b000 || busy !== 1'b0 || bus.rdat !== 32'h0) bad++;
            @(posedge clk); #2;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stop_quiet active cycles %0d want 0", bad);
        end
        for (int s = 0; s < 8; s++) st[s] = 32'h00102030;
        wr(A_PRESC, 32'h0);
        wr(A_CTRL, 32'h1);
        checks++;
        if (busy !== 1'b1 || bus.rdat !== 32'h1) begin
            errors++; $display("FAIL stop_restart busy %b status %h want 1 00000001", busy, bus.rdat);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_nstep_lower();
        logic [31:0] st [8];
        int          seen[$];
        int          want[$] = '{3, 4, 5, 6, 7, 0, 1, 0, 1};
        int          prev;
        int          waited;
        for (int s = 0; s < 8; s++) st[s] = 32'h00000000;
        st[2] = 32'h14000000;
        load_table(16'd0, 3'd3, st);
        wr(A_CTRL, 32'h3);
        waited = 0;
        while (bus.rdat[6:4] !== 3'd2 && waited < 50) begin
            @(posedge clk); #2; waited++;
        end
        wr(A_NSTEP, 32'h1);
        prev = 2;
        waited = 0;
        while (seen.size() < want.size() && waited < 200) begin
            if (int'(bus.rdat[6:4]) != prev) begin
                prev = int'(bus.rdat[6:4]);
                seen.push_back(prev);
            end
            @(posedge clk); #2; waited++;
        end
        checks++;
        if (seen != want) begin
            errors++; $display("FAIL nstep_lower steps %p want %p", seen, want);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic [31:0] s0;
        s0 = $urandom();
        wr(7'h18, s0);
        wr(7'h1B, 32'h1234ABCD);
        rd(7'h1B, d);   checks++; if (d !== 32'h1234ABCD) begin errors++; $display("FAIL step3_rb got %h want 1234abcd", d); end
        rd(7'h00, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL rd_outside got %h want 0", d); end
        rd(7'h14, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL rd_unused got %h want 0", d); end
        wr(A_NSTEP, 32'hFFFFFFFF);
        rd(A_NSTEP, d); checks++; if (d !== 32'h7) begin errors++; $display("FAIL nstep_mask got %h want 7", d); end
        wr(A_PRESC, 32'hFFFF1234);
        rd(A_PRESC, d); checks++; if (d !== 32'h1234) begin errors++; $display("FAIL presc_mask got %h want 1234", d); end
        wr(7'h01, 32'hDEADBEEF);
        wr(7'h08, 32'hCAFEF00D);
        for (int a = 4; a < 8; a++) wr(7'(7'h10 + a), $urandom());
        rd(A_PRESC, d); checks++; if (d !== 32'h1234) begin errors++; $display("FAIL decode_presc got %h want 1234", d); end
        rd(7'h18, d);   checks++; if (d !== s0) begin errors++; $display("FAIL decode_step0 got %h want %h", d, s0); end
        rd(A_CTRL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL decode_ctrl got %h want 0", d); end
        rd(A_NSTEP, d); checks++; if (d !== 32'h7) begin errors++; $display("FAIL decode_nstep got %h want 7", d); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL decode_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] st [8];
        logic [31:0] d;
        int          bad;
        for (int s = 0; s < 8; s++) st[s] = 32'h05FFFFFF;
        load_table(16'd0, 3'd7, st);
        wr(A_CTRL, 32'h3);
        repeat (300) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre busy %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++;
        if ({pwm_r, pwm_g, pwm_b, busy} !== 4'b0 || bus.rdat !== 32'h0) begin
            errors++; $display("FAIL rst_async out %b status %h want 0000 0", {pwm_r, pwm_g, pwm_b, busy}, bus.rdat);
        end
        bus.addr = A_PRESC;
        #1;
        checks++;
        if (bus.rdat !== {16'd0, PRST}) begin errors++; $display("FAIL rst_presc got %h want %h", bus.rdat, PRST); end
        @(negedge clk); reset = 1'b0; bus.addr = A_STATUS;
        bad = 0;
        repeat (300) begin
            @(posedge clk); #2;
            if ({pwm_r, pwm_g, pwm_b, busy} !== 4'b0 || bus.rdat !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_idle active cycles %0d want 0", bad); end
        rd(A_CTRL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h want 0", d); end
    endtask

    initial begin
        bus.we = 1'b0; bus.addr = A_STATUS; bus.wdat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single_shot();
        test_loop();
        test_pwm_duty();
        test_stop();
        test_nstep_lower();
        test_decode();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
